rng_scheduler: RTL and testbench

Sequencer and arbiter that shares the game's single 32-bit LFSR random source among up to NREQ requesters (enemy spawner, item drop, sound jitter, ...). It grants one requester at a time in round-robin order and advances the LFSR a fixed number of steps per draw to decorrelate successive values. It returns a uniformly distributed byte in [0, limit) using masked rejection sampling with a bounded retry count. It sits between the game-logic blocks and the LFSR, and is the only driver of the LFSR's enable input.

---
 rtl/rng_scheduler_if.sv | 15 +
 rtl/rng_scheduler.sv | 137 +++++++++++++
 tb/tb_rng_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_scheduler_if.sv
// Request/result bundle between the game-logic requesters, the shared LFSR and rng_scheduler.
interface rng_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] limit;
    logic [7:0]        lfsr_byte;
    logic              lfsr_en;
    logic [NREQ-1:0]   ack;
    logic [7:0]        value;
    logic              busy;

    modport master (output req, limit, lfsr_byte, input lfsr_en, ack, value, busy);
    modport slave  (input req, limit, lfsr_byte, output lfsr_en, ack, value, busy);
endinterface

// File: rtl/rng_scheduler.sv
// Round-robin arbiter sharing one LFSR among NREQ requesters; returns a byte in [0, limit)
// by masked rejection sampling with a bounded retry count and a fold-down fallback.
module rng_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned STEPS   = 8,
    parameter int unsigned MAX_TRY = 4
) (
    input  logic           clk,
    input  logic           rst,
    rng_scheduler_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned STW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned TRW = $clog2(MAX_TRY + 1);

    typedef enum logic [1:0] {IDLE, STEP, SAMPLE, DONE} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  winner_q;
    logic [7:0]      limit_q;
    logic [7:0]      mask_q;
    logic [7:0]      value_q;
    logic [STW-1:0]  step_cnt_q;
    logic [TRW-1:0]  try_cnt_q;
    logic            lfsr_en_q;
    logic            busy_q;
    logic [NREQ-1:0] ack_q;

    logic [NREQ-1:0] req_rot_d;
    logic [IDW-1:0]  offset_d;
    logic [IDW:0]    grant_sum_d;
    logic [IDW-1:0]  grant_id_d;
    logic            grant_vld_d;
    logic [7:0]      grant_lim_d;
    logic [7:0]      lim_m1_d;
    logic [7:0]      mask_d;
    logic [7:0]      sample_d;
    logic            accept_d;
    logic            last_try_d;

    // Rotate req so rr_ptr lands on bit 0; the lowest set bit is the next winner.
    always_comb begin
        req_rot_d   = NREQ'({bus.req, bus.req} >> rr_ptr_q);
        grant_vld_d = |bus.req;
        offset_d    = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_rot_d[k]) offset_d = IDW'(k);
        end
        grant_sum_d = {1'b0, rr_ptr_q} + {1'b0, offset_d};
        if (grant_sum_d >= (IDW+1)'(NREQ)) grant_sum_d = grant_sum_d - (IDW+1)'(NREQ);
        grant_id_d  = grant_sum_d[IDW-1:0];
        grant_lim_d = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_id_d == IDW'(i)) grant_lim_d = bus.limit[8*i +: 8];
        end
        // Smear limit-1 rightwards to get the smallest all-ones mask covering it (0 -> FF).
        lim_m1_d = grant_lim_d - 8'd1;
        mask_d   = lim_m1_d | (lim_m1_d >> 1);
        mask_d   = mask_d | (mask_d >> 2);
        mask_d   = mask_d | (mask_d >> 4);
    end

    always_comb begin
        sample_d   = bus.lfsr_byte & mask_q;
        accept_d   = (limit_q == 8'd0) || (sample_d < limit_q);
        last_try_d = (try_cnt_q == TRW'(MAX_TRY - 1));
    end

    // Sequencer; every output register is loaded with its value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            limit_q    <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            step_cnt_q <= '0;
            try_cnt_q  <= '0;
            lfsr_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    lfsr_en_q <= 1'b1;
                    busy_q    <= 1'b0;
                    if (grant_vld_d) begin
                        state_q    <= STEP;
                        winner_q   <= grant_id_d;
                        limit_q    <= grant_lim_d;
                        mask_q     <= mask_d;
                        try_cnt_q  <= '0;
                        step_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                STEP: begin
                    step_cnt_q <= step_cnt_q + STW'(1);
                    if (step_cnt_q == STW'(STEPS - 1)) begin
                        state_q   <= SAMPLE;
                        lfsr_en_q <= 1'b0;
                    end else begin
                        lfsr_en_q <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (accept_d || last_try_d) begin
                        state_q   <= DONE;
                        lfsr_en_q <= 1'b0;
                        ack_q     <= NREQ'(1) << winner_q;
                        value_q   <= accept_d ? sample_d : (sample_d - limit_q);
                    end else begin
                        state_q    <= STEP;
                        lfsr_en_q  <= 1'b1;
                        step_cnt_q <= '0;
                    end
                    if (!accept_d) try_cnt_q <= try_cnt_q + TRW'(1);
                end
                DONE: begin
                    state_q   <= IDLE;
                    lfsr_en_q <= 1'b1;
                    busy_q    <= 1'b0;
                    rr_ptr_q  <= (winner_q == IDW'(NREQ - 1)) ? '0 : winner_q + IDW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.lfsr_en = lfsr_en_q;
    assign bus.ack     = ack_q;
    assign bus.value   = value_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_rng_scheduler.sv
// Bench for rng_scheduler: owns the LFSR, predicts every output with a timeline model of a draw.
module tb_rng_scheduler;
    localparam int NREQ    = 4;
    localparam int STEPS   = 8;
    localparam int MAX_TRY = 4;
    localparam int NDRAWS  = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rng_scheduler_if #(.NREQ(NREQ)) bus ();
    rng_scheduler #(.NREQ(NREQ), .STEPS(STEPS), .MAX_TRY(MAX_TRY)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The game's LFSR, stepped only by the scheduler's enable; stub overrides its low byte.
    logic [31:0] lfsr     = 32'h1;
    logic        stub_en  = 1'b0;
    logic [7:0]  stub_val = 8'h00;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
        logic [31:0] r = s;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) lfsr <= 32'hACE1_2468;
        else if (bus.lfsr_en === 1'b1) lfsr <= lfsr_next(lfsr);
    end
    assign bus.lfsr_byte = stub_en ? stub_val : lfsr[7:0];

    task automatic chk(input bit ok, input string name, input longint got, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    endtask

    function automatic int mask_of(input int lim);
        int m   = 0;
        int top = (lim == 0) ? 255 : lim - 1;
        while (m < top) m = m * 2 + 1;
        return m;
    endfunction

    // Timeline model: a draw is a grant cycle, sample cycles every STEPS+1, then one done cycle.
    bit mvalid = 0, m_rstout = 0, m_active = 0;
    int m_rr = 0, m_win = 0, m_lim = 0, m_tries = 0, m_next = -1, m_done = -1, m_val = 0;
    int m_wait [NREQ];

    always @(negedge clk) begin : compare
        int e_en, e_busy, e_ack, s, idx;
        bit found;
        if (mvalid) begin
            e_ack = 0;
            if (m_rstout) begin e_en = 0; e_busy = 0; end
            else if (!m_active) begin e_en = 1; e_busy = 0; end
            else begin
                e_busy = 1;
                e_en   = (cyc == m_done || cyc == m_next) ? 0 : 1;
                if (cyc == m_done) e_ack = 1 << m_win;
            end
            chk(bus.lfsr_en === 1'(e_en), "lfsr_en", bus.lfsr_en, e_en);
            chk(bus.busy === 1'(e_busy), "busy", bus.busy, e_busy);
            chk(bus.ack === NREQ'(e_ack), "ack", bus.ack, e_ack);
            chk(bus.value === 8'(m_val), "value", bus.value, m_val);
            if (bus.ack !== '0) begin
                chk($onehot(bus.ack), "ack_onehot", bus.ack, e_ack);
                chk(m_lim == 0 || int'(bus.value) < m_lim, "value_range", bus.value, m_lim);
            end
            if (!m_rstout && m_active && cyc == m_done) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (i == m_win) begin
                        chk(m_wait[i] <= NREQ - 1, "fair_wait", m_wait[i], NREQ - 1);
                        m_wait[i] = 0;
                    end else if (bus.req[i] === 1'b1) m_wait[i]++;
                end
            end
        end
        if (rst) begin
            mvalid = 1; m_rstout = 1; m_active = 0; m_rr = 0; m_val = 0; m_next = -1; m_done = -1;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
        end else if (mvalid) begin
            m_rstout = 0;
            if (!m_active) begin
                if (bus.req != '0) begin
                    found = 0;
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (m_rr + k) % NREQ;
                        if (!found && bus.req[idx]) begin found = 1; m_win = idx; end
                    end
                    m_lim = int'(bus.limit[8*m_win +: 8]);
                    m_active = 1; m_tries = 0; m_done = -1; m_next = cyc + STEPS + 1;
                end
            end else if (cyc == m_done) begin
                m_active = 0; m_done = -1; m_rr = (m_win + 1) % NREQ;
            end else if (cyc == m_next) begin
                s = int'(bus.lfsr_byte) & mask_of(m_lim);
                m_next = -1;
                if (m_lim == 0 || s < m_lim) begin m_val = s; m_done = cyc + 1; end
                else begin
                    m_tries++;
                    if (m_tries == MAX_TRY) begin m_val = s - m_lim; m_done = cyc + 1; end
                    else m_next = cyc + STEPS + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_limit(input int id, input int lim);
        logic [8*NREQ-1:0] t = bus.limit;
        t[8*id +: 8] = 8'(lim);
        bus.limit = t;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int maxc, output logic [NREQ-1:0] a, output int at);
        a = '0; at = -1;
        for (int t = 0; t < maxc; t++) begin
            tick();
            if (bus.ack !== '0) begin a = bus.ack; at = cyc; break; end
        end
        if (at < 0) chk(1'b0, "ack_timeout", 0, 1);
    endtask

    // One isolated draw for requester id; reports latency, result, enable count and LFSR at cycle 1.
    task automatic do_draw(input int id, input int lim, output int lat, output int val,
                           output int en_cnt, output logic [31:0] l1);
        int g;
        tick();
        set_limit(id, lim);
        bus.req = NREQ'(1) << id;
        g = cyc; en_cnt = 0; l1 = '0; lat = -1; val = -1;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (cyc == g + 1) l1 = lfsr;
            if (bus.ack !== '0) begin
                lat = cyc - g; val = int'(bus.value);
                chk(bus.ack === NREQ'(1) << id, "draw_ack_id", bus.ack, 1 << id);
                break;
            end
            if (bus.lfsr_en === 1'b1) en_cnt++;
        end
        bus.req = '0;
        if (lat < 0) chk(1'b0, "draw_timeout", 0, 1);
    endtask

    initial begin #1_500_000; $display("FAIL watchdog cycle %0d: got running, expected finished", cyc); $fatal(1, "timeout"); end

    initial begin : stim
        int lat, val, en, at, g, acks, draws, guard;
        logic [31:0] l1;
        logic [NREQ-1:0] a, rq;
        logic [NREQ-1:0] seq [5];
        int seq_at [5];
        logic [NREQ-1:0] exp_rr [5];
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
        bus.req = '0; bus.limit = '0;
        tick(); tick();
        rst = 1'b0;
        chk(bus.lfsr_en === 1'b0, "rst_lfsr_en", bus.lfsr_en, 0);
        chk(bus.ack === '0, "rst_ack", bus.ack, 0);
        chk(bus.busy === 1'b0, "rst_busy", bus.busy, 0);
        chk(bus.value === 8'h00, "rst_value", bus.value, 0);
        tick();
        chk(bus.lfsr_en === 1'b1, "lfsr_en_rise", bus.lfsr_en, 1);

        do_draw(0, 0, lat, val, en, l1);
        chk(lat == 10, "latency", lat, 10);
        chk(en == 8, "step_en_count", en, 8);
        chk(val == int'(lfsr_adv(l1, 8) & 32'hFF), "golden_value", val, lfsr_adv(l1, 8) & 32'hFF);

        do_reset();
        bus.limit = '0; bus.req = '1; g = cyc;
        for (int n = 0; n < 5; n++) begin wait_ack(60, a, at); seq[n] = a; seq_at[n] = at; end
        bus.req = '0;
        chk(seq_at[0] - g == 10, "rr_first_latency", seq_at[0] - g, 10);
        for (int n = 0; n < 5; n++) chk(seq[n] === exp_rr[n], "rr_order", seq[n], exp_rr[n]);
        for (int n = 1; n < 5; n++) chk(seq_at[n] - seq_at[n-1] == 11, "rr_spacing", seq_at[n] - seq_at[n-1], 11);

        stub_en = 1'b1; stub_val = 8'hFF;
        do_draw(0, 5, lat, val, en, l1);
        chk(lat == 37, "fallback_latency", lat, 37);
        chk(val == 2, "fallback_value", val, 2);
        chk(en == 32, "fallback_en_count", en, 32);
        stub_en = 1'b0;
        do_draw(1, 1, lat, val, en, l1);
        chk(val == 0 && lat == 10, "limit1_value", val, 0);
        stub_en = 1'b1; stub_val = 8'h06;
        do_draw(2, 7, lat, val, en, l1);
        chk(val == 6 && lat == 10, "edge_accept", val, 6);
        stub_val = 8'h07;
        do_draw(2, 7, lat, val, en, l1);
        chk(lat == 37, "edge_reject_latency", lat, 37);
        chk(val == 0, "edge_reject_value", val, 0);
        stub_en = 1'b0;

        do_draw(1, 0, lat, val, en, l1);
        tick();
        bus.req = 4'b1000;
        tick(); tick(); tick();
        rst = 1'b1; bus.req = '0;
        tick();
        rst = 1'b0; acks = 0;
        for (int t = 0; t < 20; t++) begin tick(); if (bus.ack !== '0) acks++; end
        chk(acks == 0, "abort_no_ack", acks, 0);
        bus.req = 4'b0110;
        wait_ack(60, a, at);
        bus.req = '0;
        chk(a === 4'b0010, "abort_rr_reset", a, 4'b0010);

        tick();
        set_limit(1, 1); bus.req = 4'b0010; g = cyc;
        tick(); tick();
        set_limit(1, 0); bus.req = '0;
        wait_ack(60, a, at);
        chk(a === 4'b0010 && at - g == 10, "latched_ack", at - g, 10);
        chk(bus.value === 8'h00, "latched_limit", bus.value, 0);

        rq = '0; draws = 0; guard = 0;
        while (draws < NDRAWS && guard < 80000 && (n_chk - n_pass) < 200) begin
            tick(); guard++;
            if (bus.ack !== '0) begin draws++; rq = rq & ~bus.ack; end
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i] && $urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                    case ($urandom_range(0, 3))
                        0: set_limit(i, 0);
                        1: set_limit(i, int'($urandom_range(1, 8)));
                        default: set_limit(i, int'($urandom_range(0, 255)));
                    endcase
                end else if ($urandom_range(0, 63) == 0) set_limit(i, int'($urandom_range(0, 255)));
            end
            bus.req = rq;
        end
        bus.req = '0;
        chk(draws >= NDRAWS, "random_draws", draws, NDRAWS);
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
